// File: rtl/display_mux.sv
// Time-multiplexed digit driver: one digit lit per slot, optional dead time before each slot,
// with inputs snapshotted once per frame so a frame always shows a consistent value set.
module display_mux #(
   parameter int NUM_DIGITS   = 4,
   parameter int THRESHOLD    = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [4*NUM_DIGITS-1:0]   nums,
   input  logic [NUM_DIGITS-1:0]     digit_en,
   output logic [3:0]                numOut,
   output logic [NUM_DIGITS-1:0]     disp,
   output logic                      frame_start
);

   localparam int CNT_MAX = (THRESHOLD > BLANK_CYCLES) ? THRESHOLD : BLANK_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int IDX_W   = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(THRESHOLD - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam bit               NO_BLANK   = (BLANK_CYCLES == 0);

   generate
      if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || THRESHOLD < 1 || BLANK_CYCLES < 0) begin : g_bad_params
         $error("display_mux: illegal parameters NUM_DIGITS=%0d THRESHOLD=%0d BLANK_CYCLES=%0d",
                NUM_DIGITS, THRESHOLD, BLANK_CYCLES);
      end
   endgenerate

   typedef enum logic [1:0] {INIT, BLANK, SHOW} state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0]   nums_q, nums_d;
   logic [NUM_DIGITS-1:0]     en_q, en_d;
   logic [3:0]                num_out_q, num_out_d;
   logic [NUM_DIGITS-1:0]     disp_q, disp_d;
   logic                      fs_q, fs_d;
   logic                      slot_end;

   function automatic logic [NUM_DIGITS-1:0] onehot(input logic [IDX_W-1:0] i);
      return NUM_DIGITS'(1) << i;
   endfunction

   function automatic logic [3:0] digit_of(input logic [4*NUM_DIGITS-1:0] snap,
                                           input logic [IDX_W-1:0] i);
      return snap[4*i +: 4];
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      nums_d    = nums_q;
      en_d      = en_q;
      num_out_d = num_out_q;
      disp_d    = disp_q;
      fs_d      = 1'b0;
      slot_end  = 1'b0;

      case (state_q)
         INIT: slot_end = 1'b1;
         BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = SHOW;
               cnt_d   = '0;
               disp_d  = onehot(idx_q) & en_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SHOW: begin
            if (cnt_q == SHOW_LAST) slot_end = 1'b1;
            else                    cnt_d = cnt_q + CNT_W'(1);
         end
         default: state_d = INIT;
      endcase

      // Slot boundary: either advance to the next digit or wrap and take a fresh frame snapshot.
      if (slot_end) begin
         cnt_d = '0;
         if (state_q == INIT || idx_q == IDX_LAST) begin
            nums_d    = nums;
            en_d      = digit_en;
            idx_d     = '0;
            num_out_d = nums[3:0];
            fs_d      = 1'b1;
         end else begin
            idx_d     = idx_q + IDX_W'(1);
            num_out_d = digit_of(nums_q, idx_q + IDX_W'(1));
         end
         if (NO_BLANK) begin
            state_d = SHOW;
            disp_d  = onehot(idx_d) & en_d;
         end else begin
            state_d = BLANK;
            disp_d  = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= INIT;
         cnt_q     <= '0;
         idx_q     <= '0;
         nums_q    <= '0;
         en_q      <= '0;
         num_out_q <= '0;
         disp_q    <= '0;
         fs_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         nums_q    <= nums_d;
         en_q      <= en_d;
         num_out_q <= num_out_d;
         disp_q    <= disp_d;
         fs_q      <= fs_d;
      end
   end

   assign numOut      = num_out_q;
   assign disp        = disp_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_display_mux.sv
// Bench for display_mux: one instance with dead time (4,3,1) and one without (4,2,0),
// driven with directed vectors and checked cycle by cycle against a frame-position model.
module tb_display_mux;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] nums_a, nums_b;
   logic [3:0]  en_a, en_b;
   logic [3:0]  num_a, num_b;
   logic [3:0]  disp_a, disp_b;
   logic        fs_a, fs_b;

   int checks   = 0;
   int failures = 0;
   int viol     = 0;

   logic [15:0] snap_a, snap_b;
   logic [3:0]  sen_a, sen_b;
   logic [3:0]  pd_a = '0, pn_a = '0, pd_b = '0, pn_b = '0;

   always #5 clk = ~clk;

   display_mux #(.NUM_DIGITS(4), .THRESHOLD(3), .BLANK_CYCLES(1)) u_blank (
      .clk(clk), .reset(reset), .nums(nums_a), .digit_en(en_a),
      .numOut(num_a), .disp(disp_a), .frame_start(fs_a)
   );

   display_mux #(.NUM_DIGITS(4), .THRESHOLD(2), .BLANK_CYCLES(0)) u_noblank (
      .clk(clk), .reset(reset), .nums(nums_b), .digit_en(en_b),
      .numOut(num_b), .disp(disp_b), .frame_start(fs_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Invariants sampled on the falling edge: one-hot select, numOut steady while a digit stays lit.
   always @(negedge clk) begin
      if (reset) begin
         if ($countones(disp_a) > 1 || $countones(disp_b) > 1) viol++;
         if (disp_a != 0 && disp_a == pd_a && num_a != pn_a) viol++;
         if (disp_b != 0 && disp_b == pd_b && num_b != pn_b) viol++;
      end
      pd_a = disp_a; pn_a = num_a;
      pd_b = disp_b; pn_b = num_b;
   end

   // n = number of rising edges since reset release; edge 1 leaves INIT and captures frame 0.
   task automatic step(input int n);
      int p, slot, w;
      logic [3:0] e_disp;
      @(posedge clk);
      #1;
      p = (n - 1) % 16;
      if (p == 0) begin snap_a = nums_a; sen_a = en_a; end
      slot = p / 4;
      w    = p % 4;
      e_disp = (w == 0) ? 4'b0000 : ((4'b0001 << slot) & sen_a);
      check($sformatf("a_disp n=%0d", n), disp_a, e_disp);
      check($sformatf("a_num n=%0d", n), num_a, snap_a[slot*4 +: 4]);
      check($sformatf("a_fs n=%0d", n), fs_a, (p == 0));

      p = (n - 1) % 8;
      if (p == 0) begin snap_b = nums_b; sen_b = en_b; end
      slot = p / 2;
      e_disp = (4'b0001 << slot) & sen_b;
      check($sformatf("b_disp n=%0d", n), disp_b, e_disp);
      check($sformatf("b_num n=%0d", n), num_b, snap_b[slot*4 +: 4]);
      check($sformatf("b_fs n=%0d", n), fs_b, (p == 0));
   endtask

   initial begin
      reset  = 1'b0;
      nums_a = 16'h4321;
      en_a   = 4'b1111;
      nums_b = 16'hDCBA;
      en_b   = 4'b1111;
      snap_a = '0; sen_a = '0; snap_b = '0; sen_b = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_disp_a", disp_a, 4'b0000);
      check("rst_num_a", num_a, 4'h0);
      check("rst_fs_a", fs_a, 1'b0);
      check("rst_disp_b", disp_b, 4'b0000);
      check("rst_num_b", num_b, 4'h0);
      check("rst_fs_b", fs_b, 1'b0);

      @(negedge clk);
      reset = 1'b1;
      #1;
      check("init_disp_a", disp_a, 4'b0000);

      for (int n = 1; n <= 91; n++) begin
         step(n);
         if (n == 22) nums_a = 16'h8765;
         if (n == 48) en_a = 4'b0101;
      end

      // Edge 91 is mid-way through the digit-2 lit slot; reset must blank it at once.
      reset = 1'b0;
      #1;
      check("arst_disp_a", disp_a, 4'b0000);
      check("arst_num_a", num_a, 4'h0);
      check("arst_fs_a", fs_a, 1'b0);
      check("arst_disp_b", disp_b, 4'b0000);
      check("arst_num_b", num_b, 4'h0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      nums_a = 16'h4321;
      en_a   = 4'b1111;
      reset  = 1'b1;
      #1;
      check("rel_disp_a", disp_a, 4'b0000);

      for (int n = 1; n <= 20; n++) step(n);

      check("invariants", viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
